// File: rtl/mc_config_loader.sv
// mc_config_loader
//   Serial fuse-bitstream loader for one macrocell. A frame is CFG_BITS fuse
//   bits (frame bit 0 first) followed by one even-parity bit. Bits collect in
//   a shadow register. The shadow is copied to the active register only when
//   the parity check passes, so the macrocell never sees a partial frame.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_start           begin / restart a frame (priority over bit acceptance)
//   cfg_valid, cfg_bit  serial fuse bit strobe and data
//   cfg_ready/cfg_busy  high while a frame is being shifted in
//   cfg_loaded          1-cycle pulse after a good frame is committed
//   cfg_err             sticky parity failure of the last frame, cleared on start
//   *_mux               slices of the active register feeding the macrocell
module mc_config_loader #(
   parameter int CFG_BITS = 501,
   parameter int CNT_W    = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_start,
   input  logic         cfg_valid,
   input  logic         cfg_bit,
   output logic         cfg_ready,
   output logic         cfg_busy,
   output logic         cfg_loaded,
   output logic         cfg_err,
   output logic [479:0] ptgroupbitmap_mux,
   output logic [2:0]   oe_mux,
   output logic [1:0]   gclk_mux,
   output logic         pt1_mux,
   output logic         pt2_mux,
   output logic         pt3_mux,
   output logic         pt4_mux,
   output logic         pt5_mux,
   output logic         gclr_mux,
   output logic         pt4_func_mux,
   output logic         pt5_func_mux,
   output logic         xor_a_mux,
   output logic         xor_b_mux,
   output logic         xor_inv_mux,
   output logic         d_mux,
   output logic         dfast_mux,
   output logic         storage_mux,
   output logic         fb_mux,
   output logic         o_mux
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_BITS);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  par_q, par_d;
   logic [CFG_BITS-1:0]   shadow_q;
   logic [CFG_BITS-1:0]   active_q;
   logic                  loaded_q;
   logic                  err_q;
   logic                  shift_en, commit, err_set, err_clr;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      par_d    = par_q;
      shift_en = 1'b0;
      commit   = 1'b0;
      err_set  = 1'b0;
      err_clr  = 1'b0;
      if (cfg_start) begin
         // start works from either state and swallows any bit this cycle
         state_d = SHIFT;
         cnt_d   = '0;
         par_d   = 1'b0;
         err_clr = 1'b1;
      end else if (state_q == SHIFT && cfg_valid) begin
         if (cnt_q < LAST) begin
            shift_en = 1'b1;
            par_d    = par_q ^ cfg_bit;
            cnt_d    = cnt_q + CNT_W'(1);
         end else begin
            // this is the parity bit; frame ends either way
            state_d = IDLE;
            if ((par_q ^ cfg_bit) == 1'b0) commit  = 1'b1;
            else                           err_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         par_q    <= 1'b0;
         shadow_q <= '0;
         active_q <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         par_q    <= par_d;
         // Shift down from the top: after CFG_BITS shifts frame bit k lands
         // in shadow[k]. A restart always refills every position, so no
         // clear is needed.
         if (shift_en) shadow_q <= {cfg_bit, shadow_q[CFG_BITS-1:1]};
         if (commit)   active_q <= shadow_q;
         loaded_q <= commit;
         if (err_clr)      err_q <= 1'b0;
         else if (err_set) err_q <= 1'b1;
      end
   end

   assign cfg_ready  = (state_q == SHIFT);
   assign cfg_busy   = cfg_ready;
   assign cfg_loaded = loaded_q;
   assign cfg_err    = err_q;

   assign ptgroupbitmap_mux = active_q[479:0];
   assign oe_mux            = active_q[482:480];
   assign gclk_mux          = active_q[484:483];
   assign pt1_mux           = active_q[485];
   assign pt2_mux           = active_q[486];
   assign pt3_mux           = active_q[487];
   assign pt4_mux           = active_q[488];
   assign pt5_mux           = active_q[489];
   assign gclr_mux          = active_q[490];
   assign pt4_func_mux      = active_q[491];
   assign pt5_func_mux      = active_q[492];
   assign xor_a_mux         = active_q[493];
   assign xor_b_mux         = active_q[494];
   assign xor_inv_mux       = active_q[495];
   assign d_mux             = active_q[496];
   assign dfast_mux         = active_q[497];
   assign storage_mux       = active_q[498];
   assign fb_mux            = active_q[499];
   assign o_mux             = active_q[500];

endmodule
